multiport_reg_file: RTL



---
 rtl/multiport_reg_file.sv | 106 ++++++++++
 1 files changed

// File: rtl/multiport_reg_file.sv
// Multi-port register file: two prioritised write ports (port 1 wins), async reads,
// per-register busy scoreboard. Define RF_BYPASS_EN to forward same-cycle writes to reads.
module multiport_reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_reg1,
  input  logic [ADDR_W-1:0] rd_reg2,
  output logic [DATA_W-1:0] DAT1,
  output logic [DATA_W-1:0] DAT2,
  output logic              rd_busy1,
  output logic              rd_busy2,
  input  logic              reg_wr0,
  input  logic [ADDR_W-1:0] wr_reg0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              reg_wr1,
  input  logic [ADDR_W-1:0] wr_reg1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic              flush
);

  localparam int   NUM_REGS = 1 << ADDR_W;
  localparam logic ZR       = (ZERO_REG != 0);

  logic [DATA_W-1:0]   mem_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic                we0;
  logic                we1;
  logic                iss_en;
  logic                fwd1_p0;
  logic                fwd1_p1;
  logic                fwd2_p0;
  logic                fwd2_p1;

  function automatic logic is_zero_idx(input logic [ADDR_W-1:0] idx);
    return ZR && (idx == '0);
  endfunction

  assign we0    = reg_wr0 && !is_zero_idx(wr_reg0);
  assign we1    = reg_wr1 && !is_zero_idx(wr_reg1);
  assign iss_en = issue && !is_zero_idx(issue_reg);

  // Scoreboard: writeback or flush clears, a new issue sets (younger producer wins)
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (flush || (reg_wr0 && (wr_reg0 == ADDR_W'(r))) || (reg_wr1 && (wr_reg1 == ADDR_W'(r))))
        busy_d[r] = 1'b0;
      if (iss_en && (issue_reg == ADDR_W'(r)))
        busy_d[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Write stage: port 1 is applied last so it overrides port 0 on a shared target
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      if (we0) mem_q[wr_reg0] <= wr_data0;
      if (we1) mem_q[wr_reg1] <= wr_data1;
    end
  end

`ifdef RF_BYPASS_EN
  assign fwd1_p0 = !rst && reg_wr0 && (wr_reg0 == rd_reg1);
  assign fwd1_p1 = !rst && reg_wr1 && (wr_reg1 == rd_reg1);
  assign fwd2_p0 = !rst && reg_wr0 && (wr_reg0 == rd_reg2);
  assign fwd2_p1 = !rst && reg_wr1 && (wr_reg1 == rd_reg2);
`else
  assign fwd1_p0 = 1'b0;
  assign fwd1_p1 = 1'b0;
  assign fwd2_p0 = 1'b0;
  assign fwd2_p1 = 1'b0;
`endif

  // Read stage: zero register overrides everything, then forwarding, then array
  always_comb begin
    if (is_zero_idx(rd_reg1))  DAT1 = '0;
    else if (fwd1_p1)          DAT1 = wr_data1;
    else if (fwd1_p0)          DAT1 = wr_data0;
    else                       DAT1 = mem_q[rd_reg1];

    if (is_zero_idx(rd_reg2))  DAT2 = '0;
    else if (fwd2_p1)          DAT2 = wr_data1;
    else if (fwd2_p0)          DAT2 = wr_data0;
    else                       DAT2 = mem_q[rd_reg2];

    rd_busy1 = !is_zero_idx(rd_reg1) && !(fwd1_p0 || fwd1_p1) && busy_q[rd_reg1];
    rd_busy2 = !is_zero_idx(rd_reg2) && !(fwd2_p0 || fwd2_p1) && busy_q[rd_reg2];
  end

endmodule
